mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-clock controller that shares one simple-dual-port 4 KiB SRAM instance (write port A, registered read port B, 1-cycle read latency, no byte enables) between the instruction-fetch port and the load/store port of the FRiscV core. Arbitrates with round-robin on conflict, pipelines reads at one per cycle, and implements byte/halfword stores as a two-cycle read-modify-write. Formats load data by size and sign, and flags misaligned data accesses.

## Interface

- ARCH, 32: data width; sub-word logic is defined for 32 only.
- ADDR_WIDTH, 12: byte-address width; matches the SRAM's byte-aligned address ports.
- clk in 1: clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- if_req_in in 1: fetch request; hold with if_addr_in stable until granted.
- if_addr_in in ADDR_WIDTH: fetch byte address; bits [1:0] ignored.
- if_gnt_out out 1: fetch accepted this cycle.
- if_rvalid_out out 1: fetch data valid.
- if_rdata_out out ARCH: fetched word.
- d_req_in in 1: data request; hold with all d_* inputs stable until granted.
- d_we_in in 1: 1 = store, 0 = load.
- d_size_in in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- d_unsigned_in in 1: load zero-extends when 1, sign-extends when 0.
- d_addr_in in ADDR_WIDTH: data byte address.
- d_wdata_in in ARCH: store data, LSB-justified.
- d_gnt_out out 1: data request accepted or completed this cycle.
- d_err_out out 1: misaligned access; pulses with d_gnt_out.
- d_rvalid_out out 1: load data valid.
- d_rdata_out out ARCH: formatted load data.
- mem_addr_a_out out ADDR_WIDTH: SRAM write byte address.
- mem_din_a_out out ARCH: SRAM write data.
- mem_we_a_out out 1: SRAM write enable.
- mem_addr_b_out out ADDR_WIDTH: SRAM read byte address.
- mem_en_b_out out 1: SRAM read enable.
- mem_dout_b_in in ARCH: SRAM read data; valid the cycle after mem_en_b_out.

## Operation

- **States:** IDLE and RMW.
- **Misalignment:** a half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
- **IDLE, winner selection:**
  - Only one port requesting: that port wins.
  - Both requesting: the port other than rr_last wins.
  - rr_last updates to the winner on every grant.
- **IDLE, fetch winner:** mem_en_b_out=1, mem_addr_b_out=if_addr_in, if_gnt_out=1.
- **IDLE, data winner, misaligned:** d_gnt_out=1, d_err_out=1, no SRAM access, no d_rvalid_out.
- **IDLE, data winner, load:** mem_en_b_out=1, d_gnt_out=1; capture size, unsigned and addr[1:0].
- **IDLE, data winner, word store:** mem_we_a_out=1, mem_din_a_out=d_wdata_in, d_gnt_out=1.
- **IDLE, data winner, byte/half store:**
  - mem_en_b_out=1 at d_addr_in, no grant; go to RMW.
  - rr_last updates to data here; no conflicting fetch is granted until RMW completes.
- **RMW:**
  - Merge d_wdata_in lanes into mem_dout_b_in. Byte lane = addr[1:0]; half lanes = addr[1]*2 .. +1. Other bytes are unchanged.
  - mem_we_a_out=1, mem_addr_a_out=d_addr_in, d_gnt_out=1; return to IDLE.
  - if_gnt_out=0 and mem_en_b_out=0 throughout.
- **Load formatting:** shift the read word right by 8·offset, mask to size, then zero- or sign-extend. Word loads pass through unchanged.
- **Outputs and gating:**
  - mem_addr_*_out are don't-care when the matching enable is low.
  - Grant and SRAM enable outputs are combinational from state and inputs.
  - rvalid and rdata outputs are registered or driven from captured SRAM output.
  - While rst=1, all grant, enable and err outputs are forced to 0.

## Timing

- **Reset:**
  - State IDLE; rr_last = data, so the first conflict grants fetch.
  - if_rvalid_out=0, d_rvalid_out=0, if_rdata_out=0, d_rdata_out=0.
  - All grant, err and enable outputs 0.
- **Read latency:** rvalid is asserted exactly 1 cycle after the grant. Back-to-back reads sustain 1 per cycle; a new grant may coincide with the previous rvalid.
- **Store latency:**
  - Word store: grant and write in the same cycle.
  - Sub-word store: 2 cycles; grant and write in the second cycle.
- **Read-after-write:** a read granted the cycle after a write returns the new data, because the SRAM write commits at that edge.
- **Fairness under continuous conflict:** grants alternate fetch, data, fetch, … A sub-word store counts as a single data grant.
- **Reset mid-RMW:**
  - Return to IDLE; no write is issued.
  - A pending rvalid due the cycle after reset is suppressed.
  - The requester re-issues.
- **No cancellation:** dropping a request before its grant is illegal. Behaviour is undefined, and this is flagged by an assertion.

## Test plan

- **Fetch reads:** preload word 0x00C=0xDEADBEEF; fetch addr 0x00C → if_gnt_out in cycle 0, if_rvalid_out and if_rdata_out=0xDEADBEEF in cycle 1.
- **Conflict:** both ports request reads continuously from reset → grant order fetch, data, fetch, data; each rvalid appears 1 cycle after its grant.
- **Byte store RMW:** word 0x010=0x11223344; store byte 0xAA at 0x012 →
  - cycle 0: mem_en_b_out=1, no grant.
  - cycle 1: mem_we_a_out=1, mem_din_a_out=0x11AA3344, d_gnt_out=1.
  - A concurrent fetch is granted only in cycle 2.
- **Load formatting:** word 0x020=0x80F0017F →
  - signed byte at 0x020 → 0x0000007F.
  - signed byte at 0x023 → 0xFFFFFF80.
  - unsigned half at 0x022 → 0x000080F0.
  - signed half at 0x022 → 0xFFFF80F0.
- **Misalignment:** word store at 0x006 → d_gnt_out=1 and d_err_out=1 in the same cycle, mem_we_a_out stays 0, memory unchanged. Half load at 0x001 → err, no d_rvalid_out.
- **Reset mid-RMW:** assert rst in the RMW cycle of a half store → no write occurs, all outputs 0 the following cycle, memory unchanged. A re-issued store then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one simple-dual-port 4 KiB SRAM (write port A, registered read
//   port B with 1-cycle latency, no byte enables) between the instruction
//   fetch port and the load/store port of the FRiscV core.
//   - Round-robin arbitration when both ports request in the same cycle.
//   - Reads are pipelined at one per cycle; read data returns one cycle
//     after the grant.
//   - Word stores write in the grant cycle. Byte/halfword stores are a
//     two-cycle read-modify-write, because the SRAM has no byte enables.
//   - Load data is shifted, masked and sign/zero-extended by size.
//   - Misaligned data accesses are granted immediately with an error flag
//     and never touch the SRAM.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   if_req_in/if_addr_in fetch request and byte address ([1:0] ignored)
//   if_gnt_out           fetch accepted this cycle
//   if_rvalid_out/_rdata fetched word, one cycle after if_gnt_out
//   d_req_in, d_we_in    data request, 1 = store / 0 = load
//   d_size_in            00 byte, 01 half, 10/11 word
//   d_unsigned_in        load zero-extends when 1, sign-extends when 0
//   d_addr_in/d_wdata_in data byte address, LSB-justified store data
//   d_gnt_out/d_err_out  data accepted or completed / misaligned access
//   d_rvalid_out/_rdata  formatted load data, one cycle after d_gnt_out
//   mem_*_a_out          SRAM write port
//   mem_*_b_out          SRAM read port request
//   mem_dout_b_in        SRAM read data, valid the cycle after mem_en_b_out
//   dbg_state_out        current FSM state (0 = IDLE, 1 = RMW)
//
// Handshake:
//   A requester raises *_req_in and holds it, together with all of its
//   address/data/control inputs, stable until the cycle in which the
//   matching *_gnt_out is high. The grant is the transfer: in that cycle
//   the request is consumed and the requester may drop or replace it on the
//   next cycle. Read data arrives with *_rvalid_out exactly one cycle after
//   the grant; there is no back-pressure on the read data path. Dropping a
//   request before it is granted is illegal.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ARCH       = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_gnt_out,
  output logic                  if_rvalid_out,
  output logic [ARCH-1:0]       if_rdata_out,
  // load/store port
  input  logic                  d_req_in,
  input  logic                  d_we_in,
  input  logic [1:0]            d_size_in,
  input  logic                  d_unsigned_in,
  input  logic [ADDR_WIDTH-1:0] d_addr_in,
  input  logic [ARCH-1:0]       d_wdata_in,
  output logic                  d_gnt_out,
  output logic                  d_err_out,
  output logic                  d_rvalid_out,
  output logic [ARCH-1:0]       d_rdata_out,
  // SRAM write port A
  output logic [ADDR_WIDTH-1:0] mem_addr_a_out,
  output logic [ARCH-1:0]       mem_din_a_out,
  output logic                  mem_we_a_out,
  // SRAM read port B
  output logic [ADDR_WIDTH-1:0] mem_addr_b_out,
  output logic                  mem_en_b_out,
  input  logic [ARCH-1:0]       mem_dout_b_in,
  // debug
  output logic                  dbg_state_out
);

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_RMW    = 1'b1;

  // Which port received the most recent grant.
  localparam logic RR_FETCH = 1'b0;
  localparam logic RR_DATA  = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic       r_state;
  logic       r_rr_last;
  logic       r_if_pend;   // fetch read issued last cycle
  logic       r_d_pend;    // load read issued last cycle
  logic [1:0] r_d_size;    // captured load size
  logic       r_d_uns;     // captured load signedness
  logic [1:0] r_d_off;     // captured load byte offset

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic            w_idle;
  logic            w_rmw;
  logic            w_if_win;
  logic            w_d_win;
  logic            w_d_mis;
  logic            w_d_load;
  logic            w_d_word_store;
  logic            w_rmw_start;
  logic [ARCH-1:0] w_merged;
  logic [ARCH-1:0] w_shifted;
  logic [ARCH-1:0] w_load_fmt;

  // Folding rst into the state qualifiers forces every grant, enable and
  // error output low while reset is asserted.
  assign w_idle = !rst && (r_state == S_IDLE);
  assign w_rmw  = !rst && (r_state == S_RMW);

  // A lone requester always wins; on conflict the port that did not win
  // last time gets the slot.
  assign w_if_win = w_idle && if_req_in && (!d_req_in || (r_rr_last == RR_DATA));
  assign w_d_win  = w_idle && d_req_in  && (!if_req_in || (r_rr_last == RR_FETCH));

  // Size 11 decodes as word.
  always_comb begin
    w_d_mis = 1'b0;
    case (d_size_in)
      SZ_BYTE: w_d_mis = 1'b0;
      SZ_HALF: w_d_mis = d_addr_in[0];
      default: w_d_mis = (d_addr_in[1:0] != 2'b00);
    endcase
  end

  assign w_d_load       = w_d_win && !w_d_mis && !d_we_in;
  assign w_d_word_store = w_d_win && !w_d_mis &&  d_we_in &&  d_size_in[1];
  assign w_rmw_start    = w_d_win && !w_d_mis &&  d_we_in && !d_size_in[1];

  // ---------------------------------------------------------------------------
  // Sub-word store merge. In RMW the old word is on mem_dout_b_in; the data
  // port inputs are still held because the store has not been granted yet.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_merged = mem_dout_b_in;
    if (d_size_in == SZ_BYTE) begin
      case (d_addr_in[1:0])
        2'd0:    w_merged[7:0]   = d_wdata_in[7:0];
        2'd1:    w_merged[15:8]  = d_wdata_in[7:0];
        2'd2:    w_merged[23:16] = d_wdata_in[7:0];
        default: w_merged[31:24] = d_wdata_in[7:0];
      endcase
    end else if (d_addr_in[1]) begin
      w_merged[31:16] = d_wdata_in[15:0];
    end else begin
      w_merged[15:0]  = d_wdata_in[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting from the captured size/sign/offset.
  // ---------------------------------------------------------------------------
  assign w_shifted = mem_dout_b_in >> {r_d_off, 3'b000};

  always_comb begin
    w_load_fmt = mem_dout_b_in;
    case (r_d_size)
      SZ_BYTE: w_load_fmt = r_d_uns ? {{(ARCH-8){1'b0}}, w_shifted[7:0]}
                                    : {{(ARCH-8){w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load_fmt = r_d_uns ? {{(ARCH-16){1'b0}}, w_shifted[15:0]}
                                    : {{(ARCH-16){w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_fmt = mem_dout_b_in;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign if_gnt_out = w_if_win;

  // The RMW launch cycle takes the arbitration slot but is not a grant; the
  // grant comes with the write in the following cycle.
  assign d_gnt_out  = (w_d_win && !w_rmw_start) || w_rmw;
  assign d_err_out  = w_d_win && w_d_mis;

  assign mem_en_b_out   = w_if_win || w_d_load || w_rmw_start;
  assign mem_addr_b_out = w_if_win ? if_addr_in : d_addr_in;

  assign mem_we_a_out   = w_d_word_store || w_rmw;
  assign mem_addr_a_out = d_addr_in;
  assign mem_din_a_out  = w_rmw ? w_merged : d_wdata_in;

  // Read data is taken straight from the registered SRAM output in the
  // cycle after the grant; zero otherwise.
  assign if_rvalid_out = r_if_pend;
  assign if_rdata_out  = r_if_pend ? mem_dout_b_in : '0;
  assign d_rvalid_out  = r_d_pend;
  assign d_rdata_out   = r_d_pend ? w_load_fmt : '0;

  assign dbg_state_out = r_state;

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_last <= RR_DATA;
      r_if_pend <= 1'b0;
      r_d_pend  <= 1'b0;
      r_d_size  <= 2'b00;
      r_d_uns   <= 1'b0;
      r_d_off   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_rmw_start ? S_RMW : S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // An RMW launch already counts as the data grant for fairness.
      if (w_if_win) begin
        r_rr_last <= RR_FETCH;
      end else if (w_d_win) begin
        r_rr_last <= RR_DATA;
      end

      r_if_pend <= w_if_win;
      r_d_pend  <= w_d_load;
      if (w_d_load) begin
        r_d_size <= d_size_in;
        r_d_uns  <= d_unsigned_in;
        r_d_off  <= d_addr_in[1:0];
      end
    end
  end

`ifndef SYNTHESIS
  // A request that was waiting last cycle must still be present.
  logic r_if_wait;
  logic r_d_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_wait <= 1'b0;
      r_d_wait  <= 1'b0;
    end else begin
      r_if_wait <= if_req_in && !if_gnt_out;
      r_d_wait  <= d_req_in && !d_gnt_out;
      a_if_no_cancel: assert (!r_if_wait || if_req_in);
      a_d_no_cancel:  assert (!r_d_wait || d_req_in);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter against a behavioural SRAM and a byte-array reference
// model. Drivers push expected read data into per-port queues at grant time;
// a monitor pops and compares whenever rvalid appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT signals
  logic        if_req, if_gnt, if_rvalid;
  logic [11:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_uns, d_gnt, d_err, d_rvalid;
  logic [1:0]  d_size;
  logic [11:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [11:0] mem_addr_a, mem_addr_b;
  logic [31:0] mem_din_a, mem_dout_b;
  logic        mem_we_a, mem_en_b, dbg_state;

  mem_arbiter #(.ARCH(32), .ADDR_WIDTH(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_in      (if_req),
    .if_addr_in     (if_addr),
    .if_gnt_out     (if_gnt),
    .if_rvalid_out  (if_rvalid),
    .if_rdata_out   (if_rdata),
    .d_req_in       (d_req),
    .d_we_in        (d_we),
    .d_size_in      (d_size),
    .d_unsigned_in  (d_uns),
    .d_addr_in      (d_addr),
    .d_wdata_in     (d_wdata),
    .d_gnt_out      (d_gnt),
    .d_err_out      (d_err),
    .d_rvalid_out   (d_rvalid),
    .d_rdata_out    (d_rdata),
    .mem_addr_a_out (mem_addr_a),
    .mem_din_a_out  (mem_din_a),
    .mem_we_a_out   (mem_we_a),
    .mem_addr_b_out (mem_addr_b),
    .mem_en_b_out   (mem_en_b),
    .mem_dout_b_in  (mem_dout_b),
    .dbg_state_out  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Behavioural SRAM: write port A, registered read port B
  // ---------------------------------------------------------------------------
  logic        mem_init;
  logic [31:0] sram [0:1023];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) sram[i] <= '0;
    end else if (mem_we_a) begin
      sram[mem_addr_a[11:2]] <= mem_din_a;
    end
    if (mem_en_b) mem_dout_b <= sram[mem_addr_b[11:2]];
  end

  // ---------------------------------------------------------------------------
  // Reference model: byte-addressed memory
  // ---------------------------------------------------------------------------
  logic [7:0] ref_mem [0:4095];

  function automatic int nbytes(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] size, input logic [11:0] a);
    return (int'(a) % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [11:0] a);
    int base;
    logic [31:0] v;
    base = int'(a) & ~3;
    v = 0;
    for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [11:0] a);
    int n;
    logic [31:0] v;
    logic [7:0]  top;
    n = nbytes(size);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    top = ref_mem[int'(a) + n - 1];
    if (n < 4 && !uns && top[7]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [11:0] a, input logic [31:0] wd);
    int n;
    n = nbytes(size);
    for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic        glog[$];      // 0 = fetch grant, 1 = data grant
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: rvalid latency, read data, grant order log.
  logic prev_if_gnt = 1'b0;
  logic prev_d_ld   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_if_gnt = 1'b0;
      prev_d_ld   = 1'b0;
    end else begin
      if (if_rvalid || prev_if_gnt) begin
        chk("if_rvalid_latency", 32'(if_rvalid), 32'(prev_if_gnt));
        if (if_rvalid) begin
          if (if_exp_q.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
          else chk("if_rdata", if_rdata, if_exp_q.pop_front());
        end
      end
      if (d_rvalid || prev_d_ld) begin
        chk("d_rvalid_latency", 32'(d_rvalid), 32'(prev_d_ld));
        if (d_rvalid) begin
          if (d_exp_q.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
          else chk("d_rdata", d_rdata, d_exp_q.pop_front());
        end
      end
      if (if_gnt) glog.push_back(1'b0);
      if (d_gnt)  glog.push_back(1'b1);
      prev_if_gnt = if_gnt;
      prev_d_ld   = d_gnt && !d_we && !d_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic f_op(input logic [11:0] addr);
    int n;
    if_addr = addr;
    if_req  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!if_gnt && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!if_gnt) chk("if_gnt_timeout", 32'd0, 32'd1);
    else if_exp_q.push_back(ref_word(addr));
    step();
    if_req = 1'b0;
  endtask

  task automatic d_op(input logic we, input logic [1:0] size, input logic uns,
                      input logic [11:0] addr, input logic [31:0] wd);
    int   n;
    logic mis;
    d_we = we; d_size = size; d_uns = uns; d_addr = addr; d_wdata = wd;
    d_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!d_gnt && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!d_gnt) begin
      chk("d_gnt_timeout", 32'd0, 32'd1);
    end else begin
      mis = model_mis(size, addr);
      chk("d_err", 32'(d_err), 32'(mis));
      if (mis) begin
        chk("mis_no_write", 32'(mem_we_a), 32'd0);
        chk("mis_no_read", 32'(mem_en_b), 32'd0);
      end else if (we) begin
        ref_store(size, addr, wd);
        chk("store_we", 32'(mem_we_a), 32'd1);
        chk("store_din", mem_din_a, ref_word(addr));
      end else begin
        d_exp_q.push_back(ref_load(size, uns, addr));
      end
    end
    step();
    d_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(if_gnt),    32'd0);
    chk({tag, "_d_gnt"},     32'(d_gnt),     32'd0);
    chk({tag, "_d_err"},     32'(d_err),     32'd0);
    chk({tag, "_en_b"},      32'(mem_en_b),  32'd0);
    chk({tag, "_we_a"},      32'(mem_we_a),  32'd0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"},  32'(d_rvalid),  32'd0);
    chk({tag, "_if_rdata"},  if_rdata,       32'd0);
    chk({tag, "_d_rdata"},   d_rdata,        32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

    // Reset with both ports already requesting reads.
    rst = 1'b1; mem_init = 1'b1;
    if_req = 1'b1; if_addr = 12'h000;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_uns = 1'b0;
    d_addr = 12'h040; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'd0);
    step();
    rst = 1'b0; mem_init = 1'b0;

    // Continuous conflict: grants must alternate starting with fetch.
    glog.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) f_op(12'(i * 4));
      end
      begin
        for (int i = 0; i < 4; i++) d_op(1'b0, 2'b10, 1'b0, 12'(12'h040 + i * 4), 32'd0);
      end
    join
    chk("conflict_grants", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk($sformatf("conflict_order_%0d", i), 32'(glog[i]), 32'(i % 2));
    repeat (2) step();

    // Preload through word stores.
    d_op(1'b1, 2'b10, 1'b0, 12'h00C, 32'hDEADBEEF);
    d_op(1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344);
    d_op(1'b1, 2'b10, 1'b0, 12'h020, 32'h80F0017F);
    d_op(1'b1, 2'b11, 1'b0, 12'h030, 32'h01020304);

    // Fetch read; leaves the round-robin pointer on fetch.
    f_op(12'h00C);
    @(negedge clk);
    chk("fetch_c_rvalid", 32'(if_rvalid), 32'd1);
    chk("fetch_c_rdata", if_rdata, 32'hDEADBEEF);
    step();

    // Byte store RMW with a concurrent fetch of the same word.
    d_we = 1'b1; d_size = 2'b00; d_uns = 1'b0; d_addr = 12'h012; d_wdata = 32'h000000AA;
    d_req = 1'b1;
    if_addr = 12'h010; if_req = 1'b1;
    @(negedge clk);
    chk("rmw_c0_en_b", 32'(mem_en_b), 32'd1);
    chk("rmw_c0_d_gnt", 32'(d_gnt), 32'd0);
    chk("rmw_c0_if_gnt", 32'(if_gnt), 32'd0);
    chk("rmw_c0_we_a", 32'(mem_we_a), 32'd0);
    step();
    @(negedge clk);
    chk("rmw_c1_we_a", 32'(mem_we_a), 32'd1);
    chk("rmw_c1_din", mem_din_a, 32'h11AA3344);
    chk("rmw_c1_d_gnt", 32'(d_gnt), 32'd1);
    chk("rmw_c1_if_gnt", 32'(if_gnt), 32'd0);
    chk("rmw_c1_en_b", 32'(mem_en_b), 32'd0);
    ref_store(2'b00, 12'h012, 32'h000000AA);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("rmw_c2_if_gnt", 32'(if_gnt), 32'd1);
    if (if_gnt) if_exp_q.push_back(ref_word(12'h010));
    step();
    if_req = 1'b0;
    step();

    // Load formatting.
    d_op(1'b0, 2'b00, 1'b0, 12'h020, 32'd0);
    @(negedge clk); chk("lb_020", d_rdata, 32'h0000007F); step();
    d_op(1'b0, 2'b00, 1'b0, 12'h023, 32'd0);
    @(negedge clk); chk("lb_023", d_rdata, 32'hFFFFFF80); step();
    d_op(1'b0, 2'b01, 1'b1, 12'h022, 32'd0);
    @(negedge clk); chk("lhu_022", d_rdata, 32'h000080F0); step();
    d_op(1'b0, 2'b01, 1'b0, 12'h022, 32'd0);
    @(negedge clk); chk("lh_022", d_rdata, 32'hFFFF80F0); step();

    // Misalignment.
    d_op(1'b1, 2'b10, 1'b0, 12'h006, 32'h12345678);
    d_op(1'b0, 2'b01, 1'b0, 12'h001, 32'd0);
    @(negedge clk); chk("mis_no_rvalid", 32'(d_rvalid), 32'd0); step();

    // Reset in the RMW cycle of a half store.
    d_we = 1'b1; d_size = 2'b01; d_uns = 1'b0; d_addr = 12'h032; d_wdata = 32'h0000BEEF;
    d_req = 1'b1;
    @(negedge clk);
    chk("rstrmw_c0_en_b", 32'(mem_en_b), 32'd1);
    chk("rstrmw_c0_d_gnt", 32'(d_gnt), 32'd0);
    step();
    rst = 1'b1; d_req = 1'b0; if_req = 1'b1; if_addr = 12'h000;
    @(negedge clk);
    chk("rstrmw_c1_we_a", 32'(mem_we_a), 32'd0);
    chk("rstrmw_c1_d_gnt", 32'(d_gnt), 32'd0);
    chk("rstrmw_c1_if_gnt", 32'(if_gnt), 32'd0);
    chk("rstrmw_c1_en_b", 32'(mem_en_b), 32'd0);
    step();
    rst = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk_all_zero("after_rst");
    chk("after_rst_state", 32'(dbg_state), 32'd0);
    step();
    f_op(12'h030);
    d_op(1'b1, 2'b01, 1'b0, 12'h032, 32'h0000BEEF);
    f_op(12'h030);
    repeat (2) step();

    // Randomised concurrent traffic in a small window for frequent hazards.
    fork
      begin
        repeat (150) begin
          f_op(12'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        repeat (150) begin
          d_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               12'($urandom_range(0, 255)), $urandom);
          repeat ($urandom_range(0, 2)) step();
        end
      end
    join
    repeat (3) step();

    // Final state: queues drained, SRAM contents match the model.
    chk("if_queue_empty", 32'(if_exp_q.size()), 32'd0);
    chk("d_queue_empty", 32'(d_exp_q.size()), 32'd0);
    for (int w = 0; w < 1024; w++)
      chk($sformatf("mem_word_%03h", w * 4), sram[w], ref_word(12'(w * 4)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
